// File: rtl/sdc_block_sequencer.sv
// rtl/sdc_block_sequencer.sv - SD-card write data path bit/phase sequencer
module sdc_block_sequencer #(
    parameter int BLOCK_BYTES  = 512,
    parameter int BUS_WIDTH    = 1,
    parameter int CRC_BITS     = 16,
    parameter int BLK_W        = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             resetCounter,
    input  logic             start,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             byte_enable,
    input  logic             card_busy,
    input  logic             abort,
    output logic             start_bit,
    output logic             shift,
    output logic             load,
    output logic             byte_done,
    output logic             block_done,
    output logic             crc_shift,
    output logic             crc_clear,
    output logic             end_bit,
    output logic             busy_wait,
    output logic             done,
    output logic             timeout,
    output logic             aborted,
    output logic [BLK_W-1:0] blocks_left
);

    localparam int DCYC   = BLOCK_BYTES * 8 / BUS_WIDTH;
    localparam int DCNT_W = $clog2(DCYC) + 1;
    localparam int BPC    = 8 / BUS_WIDTH;
    localparam int BPC_W  = $clog2(BPC);
    localparam int CCNT_W = $clog2(CRC_BITS + 1);
    localparam int BCNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CRC,
        S_STOP,
        S_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [DCNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic [CCNT_W-1:0]   crc_cnt_q, crc_cnt_d;
    logic [BCNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic [BLK_W-1:0]    blocks_left_q, blocks_left_d;
    logic [BPC_W-1:0]    in_byte;

    // Position within the current byte; BPC is a power of two so low bits suffice.
    assign in_byte     = data_cnt_q[BPC_W-1:0];
    assign blocks_left = blocks_left_q;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (resetCounter) begin
            state_q       <= S_IDLE;
            data_cnt_q    <= '0;
            crc_cnt_q     <= '0;
            busy_cnt_q    <= '0;
            blocks_left_q <= '0;
        end else begin
            state_q       <= state_d;
            data_cnt_q    <= data_cnt_d;
            crc_cnt_q     <= crc_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
            blocks_left_q <= blocks_left_d;
        end
    end

    // Next-state, counter and strobe decode; abort overrides every phase transition.
    always_comb begin
        state_d       = state_q;
        data_cnt_d    = data_cnt_q;
        crc_cnt_d     = crc_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        blocks_left_d = blocks_left_q;
        start_bit     = 1'b0;
        shift         = 1'b0;
        load          = 1'b0;
        byte_done     = 1'b0;
        block_done    = 1'b0;
        crc_shift     = 1'b0;
        crc_clear     = 1'b0;
        end_bit       = 1'b0;
        busy_wait     = 1'b0;
        done          = 1'b0;
        timeout       = 1'b0;
        aborted       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_START;
                    blocks_left_d = (num_blocks == '0) ? BLK_W'(1) : num_blocks;
                end
            end
            S_START: begin
                start_bit = 1'b1;
                crc_clear = 1'b1;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (byte_enable) begin
                    shift     = 1'b1;
                    load      = (in_byte == '0);
                    byte_done = (in_byte == BPC_W'(BPC - 1));
                    if (data_cnt_q == DCNT_W'(DCYC - 1)) begin
                        block_done = 1'b1;
                        state_d    = S_CRC;
                    end else begin
                        data_cnt_d = data_cnt_q + DCNT_W'(1);
                    end
                end
            end
            S_CRC: begin
                crc_shift = 1'b1;
                if (crc_cnt_q == CCNT_W'(CRC_BITS - 1)) begin
                    state_d = S_STOP;
                end else begin
                    crc_cnt_d = crc_cnt_q + CCNT_W'(1);
                end
            end
            S_STOP: begin
                end_bit = 1'b1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                busy_wait = 1'b1;
                // The first two cycles are the Nwr gap where DAT0 is not yet meaningful.
                if (busy_cnt_q >= BCNT_W'(2) && !card_busy) begin
                    if (blocks_left_q <= BLK_W'(1)) begin
                        blocks_left_d = '0;
                        done          = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        blocks_left_d = blocks_left_q - BLK_W'(1);
                        state_d       = S_START;
                    end
                end else if (busy_cnt_q == BCNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout       = 1'b1;
                    blocks_left_d = '0;
                    state_d       = S_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            aborted       = 1'b1;
            done          = 1'b0;
            timeout       = 1'b0;
            blocks_left_d = '0;
        end

        // Every counter restarts from zero whenever the phase changes.
        if (state_d != state_q) begin
            data_cnt_d = '0;
            crc_cnt_d  = '0;
            busy_cnt_d = '0;
        end

        // A reset cycle must not be reported as a completed, timed-out or aborted run.
        if (resetCounter) begin
            done    = 1'b0;
            timeout = 1'b0;
            aborted = 1'b0;
        end
    end

endmodule
